// File: rtl/tile_cmd_sched.sv
// tile_cmd_sched
//   Queues PS/2 key-release scancodes, decodes them into 3x3 tile colour
//   operations and applies them one tile write per cycle, only while the
//   beam is in vertical blanking. Also provides the registered colour
//   lookup for the tile under the beam.
// Ports:
//   clk       pixel-rate clock
//   reset     synchronous, active-high
//   scancode  released-key scancode, valid with flag
//   flag      single-cycle key-release strobe
//   vblank    high outside the visible area; tile writes only then
//   region    tile index 1..9 under the beam, 0 = outside the grid
//   rgb       registered {r,g,b} colour of the tile at region
//   busy      queue non-empty or a command in progress
//   overflow  sticky, an event was dropped on a full queue
module tile_cmd_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       flag,
  input  logic       vblank,
  input  logic [3:0] region,
  output logic [8:0] rgb,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DECODE = 2'd1, S_SAVE = 2'd2, S_EXEC = 2'd3} state_t;
  typedef enum logic [1:0] {OP_PAINT = 2'd0, OP_CLEAR = 2'd1, OP_INVERT = 2'd2, OP_ROT = 2'd3} op_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  op_t           r_op;
  logic [7:0]    r_cmd;
  logic [3:0]    r_sel;
  logic [8:0]    r_color;
  logic [3:0]    r_step;
  logic [8:0]    r_tmp;
  logic [8:0]    r_tile [1:9];
  logic [8:0]    r_rgb;

  logic          w_full, w_empty, w_push, w_pop;
  logic [3:0]    w_dst, w_src, w_last;
  logic [8:0]    w_dst_val, w_src_val, w_wdata, w_cmd_color, w_rd_val;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == {(AW+1){1'b0}});
  // A full queue blocks a push even if the scheduler pops in the same cycle.
  assign w_push  = flag & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;

  assign rgb      = r_rgb;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) | ~w_empty;

  // Event queue storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= scancode;
        r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      if (flag && w_full) r_overflow <= 1'b1;
    end
  end

  // Colour carried by a paint scancode.
  always_comb begin
    w_cmd_color = 9'h000;
    case (r_cmd)
      8'h2D:   w_cmd_color = 9'b111000000;
      8'h34:   w_cmd_color = 9'b000111000;
      8'h32:   w_cmd_color = 9'b000000111;
      8'h1C:   w_cmd_color = 9'h1FF;
      8'h3A:   w_cmd_color = 9'h000;
      default: w_cmd_color = 9'h000;
    endcase
  end

  // Destination/source tile and final step index for the current write.
  always_comb begin
    w_dst  = 4'd0;
    w_src  = 4'd0;
    w_last = 4'd0;
    case (r_op)
      OP_PAINT: begin
        w_dst  = r_sel;
        w_last = 4'd0;
      end
      OP_CLEAR, OP_INVERT: begin
        w_dst  = r_step + 4'd1;
        w_last = 4'd8;
      end
      OP_ROT: begin
        // Clockwise ring walk; tile 1 was saved in r_tmp and lands in tile 2.
        w_last = 4'd7;
        case (r_step)
          4'd0:    begin w_dst = 4'd1; w_src = 4'd4; end
          4'd1:    begin w_dst = 4'd4; w_src = 4'd7; end
          4'd2:    begin w_dst = 4'd7; w_src = 4'd8; end
          4'd3:    begin w_dst = 4'd8; w_src = 4'd9; end
          4'd4:    begin w_dst = 4'd9; w_src = 4'd6; end
          4'd5:    begin w_dst = 4'd6; w_src = 4'd3; end
          4'd6:    begin w_dst = 4'd3; w_src = 4'd2; end
          4'd7:    begin w_dst = 4'd2; w_src = 4'd0; end
          default: begin w_dst = 4'd0; w_src = 4'd0; end
        endcase
      end
      default: begin
        w_dst  = 4'd0;
        w_last = 4'd0;
      end
    endcase
  end

  // Tile store lookups for the write datapath and the beam read path.
  always_comb begin
    w_dst_val = 9'h000;
    w_src_val = 9'h000;
    w_rd_val  = 9'h000;
    for (int i = 1; i <= 9; i++) begin
      if (w_dst == 4'(i))  w_dst_val = r_tile[i];
      if (w_src == 4'(i))  w_src_val = r_tile[i];
      if (region == 4'(i)) w_rd_val  = r_tile[i];
    end
  end

  // Data written to the destination tile this step.
  always_comb begin
    w_wdata = 9'h000;
    case (r_op)
      OP_PAINT:  w_wdata = r_color;
      OP_CLEAR:  w_wdata = 9'h000;
      OP_INVERT: w_wdata = ~w_dst_val;
      OP_ROT:    w_wdata = (r_step == 4'd7) ? r_tmp : w_src_val;
      default:   w_wdata = 9'h000;
    endcase
  end

  // Command FSM and tile store; writes happen only in EXEC during vblank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_PAINT;
      r_cmd   <= 8'h00;
      r_sel   <= 4'd0;
      r_color <= 9'h000;
      r_step  <= 4'd0;
      r_tmp   <= 9'h000;
      for (int i = 1; i <= 9; i++) r_tile[i] <= 9'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cmd   <= r_mem[r_rd_ptr];
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_step  <= 4'd0;
          r_state <= S_IDLE;
          case (r_cmd)
            8'h16: r_sel <= 4'd1;
            8'h1E: r_sel <= 4'd2;
            8'h26: r_sel <= 4'd3;
            8'h25: r_sel <= 4'd4;
            8'h2E: r_sel <= 4'd5;
            8'h36: r_sel <= 4'd6;
            8'h3D: r_sel <= 4'd7;
            8'h3E: r_sel <= 4'd8;
            8'h46: r_sel <= 4'd9;
            8'h2D, 8'h34, 8'h32, 8'h1C, 8'h3A: begin
              if (r_sel != 4'd0) begin
                r_op    <= OP_PAINT;
                r_color <= w_cmd_color;
                r_state <= S_EXEC;
              end
            end
            8'h45: begin r_op <= OP_CLEAR;  r_state <= S_EXEC; end
            8'h43: begin r_op <= OP_INVERT; r_state <= S_EXEC; end
            8'h21: begin r_op <= OP_ROT;    r_state <= S_SAVE; end
            default: r_state <= S_IDLE;
          endcase
        end
        S_SAVE: begin
          if (vblank) begin
            r_tmp   <= r_tile[1];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (vblank) begin
            for (int i = 1; i <= 9; i++) begin
              if (w_dst == 4'(i)) r_tile[i] <= w_wdata;
            end
            if (r_step == w_last) begin
              r_step  <= 4'd0;
              r_state <= S_IDLE;
            end else begin
              r_step  <= r_step + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered colour of the tile under the beam.
  always_ff @(posedge clk) begin
    if (reset) r_rgb <= 9'h000;
    else       r_rgb <= w_rd_val;
  end

endmodule

// File: tb/tb_tile_cmd_sched.sv
// Directed self-checking bench for tile_cmd_sched.
module tb_tile_cmd_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic       vblank;
  logic [3:0] region;
  logic [8:0] rgb;
  logic       busy;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_t [1:9];
  logic [7:0] sel_code [1:9];
  logic [7:0] col_code [1:9];
  logic [8:0] col_val  [1:9];
  logic [7:0] ovf_code [6];

  always #20 clk = ~clk;

  tile_cmd_sched #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .vblank(vblank), .region(region), .rgb(rgb), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic key(input logic [7:0] c);
    @(negedge clk);
    scancode = c;
    flag     = 1'b1;
    @(negedge clk);
    flag     = 1'b0;
    scancode = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic rd(input logic [3:0] t, input logic [8:0] e, input string tag);
    @(negedge clk);
    region = t;
    @(posedge clk);
    #1;
    chk($sformatf("%s_tile%0d", tag, t), {23'd0, rgb}, {23'd0, e});
  endtask

  task automatic check_tiles(input string tag);
    for (int i = 1; i <= 9; i++) rd(4'(i), exp_t[i], tag);
  endtask

  task automatic set_exp(input logic [8:0] v);
    for (int i = 1; i <= 9; i++) exp_t[i] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel_code = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    // Pattern before rotate: R G B W K R G B W
    col_code = '{8'h2D, 8'h34, 8'h32, 8'h1C, 8'h3A, 8'h2D, 8'h34, 8'h32, 8'h1C};
    col_val  = '{9'h1C0, 9'h038, 9'h007, 9'h1FF, 9'h000, 9'h1C0, 9'h038, 9'h007, 9'h1FF};
    ovf_code = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};

    reset = 1'b1; flag = 1'b0; scancode = 8'h00; vblank = 1'b0; region = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rgb", {23'd0, rgb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Paint with no selection: no write, idle within 3 cycles.
    vblank = 1'b1;
    key(8'h34);
    repeat (3) @(posedge clk);
    #1;
    chk("nosel_busy", {31'd0, busy}, 32'd0);
    set_exp(9'h000);
    check_tiles("nosel");

    // Select tile 3, paint red; rgb follows one cycle after the write.
    key(8'h26);
    wait_idle("sel3_idle");
    @(negedge clk);
    region = 4'd3;
    key(8'h2D);
    repeat (3) @(posedge clk);
    #1;
    chk("paint_rgb_lag", {23'd0, rgb}, 32'd0);
    @(posedge clk);
    #1;
    chk("paint_rgb", {23'd0, rgb}, 32'h1C0);
    exp_t[3] = 9'h1C0;
    check_tiles("paint");

    // Build a pattern, then rotate the ring clockwise.
    for (int i = 1; i <= 9; i++) begin
      key(sel_code[i]);
      key(col_code[i]);
      wait_idle($sformatf("build%0d_idle", i));
      exp_t[i] = col_val[i];
    end
    check_tiles("pattern");
    key(8'h21);
    repeat (10) @(posedge clk);
    #1;
    chk("rot_busy_n10", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("rot_busy_n11", {31'd0, busy}, 32'd0);
    exp_t[1] = 9'h1FF; exp_t[2] = 9'h1C0; exp_t[3] = 9'h038;
    exp_t[4] = 9'h038; exp_t[5] = 9'h000; exp_t[6] = 9'h007;
    exp_t[7] = 9'h007; exp_t[8] = 9'h1FF; exp_t[9] = 9'h1C0;
    check_tiles("rot");

    // Clear, then invert stalled by vblank low.
    key(8'h45);
    wait_idle("clr_idle");
    set_exp(9'h000);
    check_tiles("clr");
    @(negedge clk);
    vblank = 1'b0;
    key(8'h43);
    repeat (20) @(negedge clk);
    chk("inv_stall_busy", {31'd0, busy}, 32'd1);
    rd(4'd1, 9'h000, "inv_stall");
    rd(4'd9, 9'h000, "inv_stall");
    @(negedge clk);
    vblank = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("inv_busy_w8", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("inv_busy_w9", {31'd0, busy}, 32'd0);
    set_exp(9'h1FF);
    check_tiles("inv");

    // Overflow: stall an invert, then six selects into a 4-deep queue.
    @(negedge clk);
    vblank = 1'b0;
    key(8'h43);
    repeat (3) @(negedge clk);
    chk("ovf_pre", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      key(ovf_code[i]);
      @(negedge clk);
    end
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    vblank = 1'b1;
    wait_idle("ovf_drain_idle");
    chk("ovf_sticky2", {31'd0, overflow}, 32'd1);
    // Last accepted select was tile 4; dropped ones were tiles 5 and 6.
    key(8'h2D);
    wait_idle("ovf_paint_idle");
    set_exp(9'h000);
    exp_t[4] = 9'h1C0;
    check_tiles("ovf");

    // Mid-operation reset during clear-all.
    key(8'h43);
    wait_idle("pre_rst_inv_idle");
    key(8'h1C);
    wait_idle("pre_rst_paint_idle");
    set_exp(9'h1FF);
    check_tiles("pre_rst");
    @(negedge clk);
    region = 4'd5;
    key(8'h45);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rgb_t5", {23'd0, rgb}, 32'h1FF);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_rgb", {23'd0, rgb}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_busy_after", {31'd0, busy}, 32'd0);
    set_exp(9'h000);
    check_tiles("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
